iqmu_mc: RTL and testbench

Multi-lane, multi-channel inverse quality modulating unit for the synthesis/decoding path, upstream of the PreTA transform. Each beat carries LANES signed samples for one channel. Each sample is scaled up by 2^mode, where mode is a per-channel value held in a programmable table, then saturated to DATA_W. Successor to the single-lane, fixed-mode dequantizer: adds a per-channel mode table, wider shift range, valid/ready backpressure, correct signed handling and saturation telemetry.

---
 rtl/iqmu_pkg.sv | 23 ++
 rtl/iqmu_lane.sv | 37 +++
 rtl/iqmu_mc.sv | 134 +++++++++++++
 tb/tb_iqmu_mc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iqmu_pkg.sv
// Shared constants and helpers for the inverse quality modulating unit.
// Widths are passed in so every parameterisation of the unit shares one package.
package iqmu_pkg;

  // Width that holds a DATA_W sample shifted left by the largest mode with no loss.
  function automatic int wide_w(input int data_w, input int mode_w);
    return data_w + (1 << mode_w) - 1;
  endfunction

  function automatic longint sat_max(input int data_w);
    return (longint'(1) << (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_w);
    return -(longint'(1) << (data_w - 1));
  endfunction

  // Lane i occupies bits [i*data_w +: data_w] of a packed beat.
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/iqmu_lane.sv
// One lane of the datapath: sign-extend, shift left by mode, saturate to DATA_W.
// Purely combinational; sits between the S1 and S2 registers of iqmu_mc.
module iqmu_lane
  import iqmu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MODE_W = 3
) (
  input  logic [DATA_W-1:0] i_sample,
  input  logic [MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0] o_value,
  output logic              o_sat
);

  localparam int WW = wide_w(DATA_W, MODE_W);
  localparam logic signed [WW-1:0] MAX_W = WW'(sat_max(DATA_W));
  localparam logic signed [WW-1:0] MIN_W = WW'(sat_min(DATA_W));

  logic signed [WW-1:0] w_ext;
  logic signed [WW-1:0] w_shift;

  assign w_ext   = {{(WW-DATA_W){i_sample[DATA_W-1]}}, i_sample};
  assign w_shift = w_ext <<< i_mode;

  always_comb begin
    o_value = w_shift[DATA_W-1:0];
    o_sat   = 1'b0;
    if (w_shift > MAX_W) begin
      o_value = MAX_W[DATA_W-1:0];
      o_sat   = 1'b1;
    end else if (w_shift < MIN_W) begin
      o_value = MIN_W[DATA_W-1:0];
      o_sat   = 1'b1;
    end
  end

endmodule

// File: rtl/iqmu_mc.sv
// Multi-lane, multi-channel inverse quality modulator: per-channel mode table,
// two-stage pipeline (S1 capture, S2 saturate/register) and saturation telemetry.
module iqmu_mc
  import iqmu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int NUM_CH = 8,
  parameter int MODE_W = 3,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [MODE_W-1:0]       cfg_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  input  logic                    sat_clr,
  output logic [15:0]             sat_count
);

  // Handshake: a beat moves on a port only in a cycle where valid && ready are
  // both high at the clock edge; a producer holding valid keeps its payload stable.

  logic [MODE_W-1:0]       r_mode_tbl [NUM_CH];
  logic [MODE_W-1:0]       w_rd_mode;

  logic                    r_s1_valid;
  logic [CH_W-1:0]         r_s1_ch;
  logic [MODE_W-1:0]       r_s1_mode;
  logic [LANES*DATA_W-1:0] r_s1_data;

  logic                    r_s2_valid;
  logic [CH_W-1:0]         r_out_ch;
  logic [LANES*DATA_W-1:0] r_out_data;
  logic [LANES-1:0]        r_out_sat;
  logic [15:0]             r_sat_cnt;

  logic [LANES*DATA_W-1:0] w_lane_val;
  logic [LANES-1:0]        w_lane_sat;
  logic                    w_s1_en;
  logic                    w_s2_en;
  logic                    w_out_hs;

  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign w_out_hs = r_s2_valid && out_ready;

  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_cnt;

  // Unmapped indices (only reachable when NUM_CH is not a power of 2) read as mode 0.
  always_comb begin
    w_rd_mode = '0;
    if (32'(in_ch) < NUM_CH) w_rd_mode = r_mode_tbl[in_ch];
  end

  // The table is a register, so a same-cycle write is seen only by later beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_mode_tbl[i] <= '0;
    end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      r_mode_tbl[cfg_ch] <= cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_mode  <= '0;
      r_s1_data  <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_ch   <= in_ch;
        r_s1_mode <= w_rd_mode;
        r_s1_data <= in_data;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    iqmu_lane #(
      .DATA_W (DATA_W),
      .MODE_W (MODE_W)
    ) u_lane (
      .i_sample (r_s1_data[lane_lsb(g, DATA_W) +: DATA_W]),
      .i_mode   (r_s1_mode),
      .o_value  (w_lane_val[lane_lsb(g, DATA_W) +: DATA_W]),
      .o_sat    (w_lane_sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_ch   <= '0;
      r_out_data <= '0;
      r_out_sat  <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_ch   <= r_s1_ch;
        r_out_data <= w_lane_val;
        r_out_sat  <= w_lane_sat;
      end
    end
  end

  // Clear has priority over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_out_hs && (|r_out_sat) && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_iqmu_mc.sv
// Directed bench for iqmu_mc: scenario tasks with inline checks and a final report.
module tb_iqmu_mc;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int NUM_CH = 8;
  localparam int MODE_W = 3;
  localparam int CH_W   = 3;
  localparam int BW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [MODE_W-1:0] cfg_mode = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch = '0;
  logic [BW-1:0]     in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_ch;
  logic [BW-1:0]     out_data;
  logic [LANES-1:0]  out_sat;
  logic              sat_clr = 1'b0;
  logic [15:0]       sat_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard entry: {ch, sat, data}
  logic [CH_W+LANES+BW-1:0] exp_q[$];

  iqmu_mc #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .NUM_CH (NUM_CH),
    .MODE_W (MODE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors / %0d miscompares", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [CH_W-1:0] ch, input logic [MODE_W-1:0] mode);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    step();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [BW-1:0] mk_beat(input int k);
    logic [15:0] a, b, c, d;
    a = 16'(k * 37);
    b = 16'(-k * 200);
    c = 16'(k * 700);
    d = 16'(32'h8000 + k);
    return {d, c, b, a};
  endfunction

  // Reference: multiply by 2^mode in plain integers and clamp to 16-bit signed.
  function automatic logic [CH_W+LANES+BW-1:0] model(input logic [CH_W-1:0] ch, input int mode,
                                                     input logic [BW-1:0] d);
    logic [BW-1:0]    o;
    logic [LANES-1:0] s;
    int               v;
    for (int i = 0; i < LANES; i++) begin
      v = int'($signed(d[i*DATA_W +: DATA_W])) * (1 << mode);
      if (v > 32767) begin
        o[i*DATA_W +: DATA_W] = 16'h7FFF;
        s[i] = 1'b1;
      end else if (v < -32768) begin
        o[i*DATA_W +: DATA_W] = 16'h8000;
        s[i] = 1'b1;
      end else begin
        o[i*DATA_W +: DATA_W] = 16'(v);
        s[i] = 1'b0;
      end
    end
    return {ch, s, o};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec_cnt++; if (out_data !== '0) begin err_cnt++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vec_cnt++; if (out_ch !== '0) begin err_cnt++; $display("FAIL reset_out_ch got %h want 0", out_ch); end
    vec_cnt++; if (out_sat !== '0) begin err_cnt++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    vec_cnt++; if (sat_count !== 16'h0) begin err_cnt++; $display("FAIL reset_sat_count got %h want 0", sat_count); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mode2();
    prog(3'd3, 3'd2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ch     = 3'd3;
    in_data   = {16'h2000, 16'h1FFF, 16'hFF00, 16'h0100};
    step();
    in_valid  = 1'b0;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mode2_latency1 out_valid got %b want 0", out_valid); end
    step();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL mode2_latency2 out_valid got %b want 1", out_valid); end
    vec_cnt++; if (out_data !== {16'h7FFF, 16'h7FFC, 16'hFC00, 16'h0400}) begin err_cnt++; $display("FAIL mode2_data got %h want 7fff7ffcfc000400", out_data); end
    vec_cnt++; if (out_sat !== 4'b1000) begin err_cnt++; $display("FAIL mode2_sat got %b want 1000", out_sat); end
    vec_cnt++; if (out_ch !== 3'd3) begin err_cnt++; $display("FAIL mode2_ch got %0d want 3", out_ch); end
    step();
    vec_cnt++; if (sat_count !== 16'd1) begin err_cnt++; $display("FAIL mode2_sat_count got %0d want 1", sat_count); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mode2_drain out_valid got %b want 0", out_valid); end
  endtask

  // Lane 3 lands on exactly -32768, which fits and is not flagged.
  task automatic test_mode7();
    prog(3'd0, 3'd7);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ch     = 3'd0;
    in_data   = {16'hFF00, 16'h0100, 16'hFFFF, 16'h0001};
    step();
    in_valid  = 1'b0;
    step();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL mode7_valid got %b want 1", out_valid); end
    vec_cnt++; if (out_data !== {16'h8000, 16'h7FFF, 16'hFF80, 16'h0080}) begin err_cnt++; $display("FAIL mode7_data got %h want 80007fffff800080", out_data); end
    vec_cnt++; if (out_sat !== 4'b0100) begin err_cnt++; $display("FAIL mode7_sat got %b want 0100", out_sat); end
    step();
    vec_cnt++; if (sat_count !== 16'd2) begin err_cnt++; $display("FAIL mode7_sat_count got %0d want 2", sat_count); end
  endtask

  task automatic test_back_to_back();
    int               sent, got, occ;
    logic             acc, del, prev_stall, exp_rdy;
    logic [BW-1:0]    prev_data;
    logic [CH_W+LANES+BW-1:0] e;
    sent = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_data = '0;
    prog(3'd5, 3'd3);
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 16);
      in_ch     = 3'd5;
      in_data   = mk_beat(sent);
      #1;
      exp_rdy = !((occ == 2) && !out_ready);
      vec_cnt++; if (in_ready !== exp_rdy) begin err_cnt++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
      if (prev_stall) begin
        vec_cnt++; if (out_data !== prev_data) begin err_cnt++; $display("FAIL b2b_hold cyc %0d got %h want %h", cyc, out_data, prev_data); end
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++; $display("FAIL b2b_extra_beat cyc %0d got %h want none", cyc, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_ch, out_sat, out_data} !== e) begin
            err_cnt++; $display("FAIL b2b_beat %0d got %h want %h", got, {out_ch, out_sat, out_data}, e);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (acc) begin
        exp_q.push_back(model(3'd5, 3, mk_beat(sent)));
        sent++;
      end
      occ = occ + int'(acc) - int'(del);
      step();
    end
    in_valid = 1'b0;
    vec_cnt++; if (got != 16) begin err_cnt++; $display("FAIL b2b_timeout got %0d beats want 16", got); end
    exp_q.delete();
  endtask

  task automatic test_same_cycle_write();
    out_ready = 1'b1;
    cfg_we    = 1'b1;
    cfg_ch    = 3'd1;
    cfg_mode  = 3'd1;
    in_valid  = 1'b1;
    in_ch     = 3'd1;
    in_data   = {4{16'h0010}};
    step();
    cfg_we    = 1'b0;
    step();
    in_valid  = 1'b0;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL rbw_old_valid got %b want 1", out_valid); end
    vec_cnt++; if (out_data !== {4{16'h0010}}) begin err_cnt++; $display("FAIL rbw_old_mode got %h want 0010 per lane", out_data); end
    vec_cnt++; if (out_ch !== 3'd1) begin err_cnt++; $display("FAIL rbw_ch got %0d want 1", out_ch); end
    step();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL rbw_new_valid got %b want 1", out_valid); end
    vec_cnt++; if (out_data !== {4{16'h0020}}) begin err_cnt++; $display("FAIL rbw_new_mode got %h want 0020 per lane", out_data); end
    step();
  endtask

  task automatic test_sat_count();
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    step();
    sat_clr   = 1'b0;
    vec_cnt++; if (sat_count !== 16'h0) begin err_cnt++; $display("FAIL satcnt_clear got %h want 0", sat_count); end
    in_valid  = 1'b1;
    in_ch     = 3'd3;
    in_data   = {16'h2000, 48'h0};
    repeat (65535) step();
    in_valid  = 1'b0;
    repeat (3) step();
    vec_cnt++; if (sat_count !== 16'hFFFF) begin err_cnt++; $display("FAIL satcnt_fill got %h want ffff", sat_count); end
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    repeat (3) step();
    vec_cnt++; if (sat_count !== 16'hFFFF) begin err_cnt++; $display("FAIL satcnt_nowrap got %h want ffff", sat_count); end
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
    vec_cnt++; if ((out_valid !== 1'b1) || (out_sat !== 4'b1000)) begin err_cnt++; $display("FAIL satcnt_clip_beat got valid %b sat %b want 1 1000", out_valid, out_sat); end
    sat_clr   = 1'b1;
    step();
    sat_clr   = 1'b0;
    vec_cnt++; if (sat_count !== 16'h0) begin err_cnt++; $display("FAIL satcnt_clr_wins got %h want 0", sat_count); end
  endtask

  task automatic test_reset_midstream();
    prog(3'd2, 3'd4);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ch     = 3'd2;
    in_data   = {4{16'h0001}};
    step();
    step();
    in_valid  = 1'b0;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL rstmid_inflight got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_async_drop got %b want 0", out_valid); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stale cyc %0d got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL rstmid_post_valid got %b want 1", out_valid); end
    vec_cnt++; if (out_data !== {4{16'h0001}}) begin err_cnt++; $display("FAIL rstmid_table_cleared got %h want 0001 per lane", out_data); end
    vec_cnt++; if (out_sat !== 4'b0000) begin err_cnt++; $display("FAIL rstmid_sat got %b want 0000", out_sat); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mode2();
    test_mode7();
    test_back_to_back();
    test_same_cycle_write();
    test_sat_count();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
